// File: rtl/matmul_engine.sv
// Sequential multiply-accumulate engine computing C = A x B from register-file operands.
// Define MATMUL_SIGNED_EN for two's-complement operands and results.
module matmul_engine #(
  parameter int DW = 8,
  parameter int M  = 2,
  parameter int K  = 3,
  parameter int N  = 3,
  parameter int AW = 2,
  localparam int OW = 2*DW + $clog2(K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data_in,
  input  logic          mem_sel,
  input  logic [DW-1:0] data,
  input  logic [AW-1:0] row_in,
  input  logic [AW-1:0] col_in,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] row_out,
  input  logic [AW-1:0] col_out,
`ifdef MATMUL_SIGNED_EN
  output logic signed [OW-1:0] out
`else
  output logic [OW-1:0] out
`endif
);

  // state | meaning
  // IDLE  | waiting for start, operand writes accepted
  // MAC   | one A[i][k]*B[k][j] term per cycle, busy=1
  // DONE  | single-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q;
  logic          busy_q, done_q;
  logic [IW-1:0] i_q;
  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic [OW-1:0] acc_q, acc_d;
  logic [OW-1:0] out_q, rd_d;

  logic [DW-1:0] a_q [M][K];
  logic [DW-1:0] b_q [K][N];
  logic [OW-1:0] c_q [M][N];

  logic [DW-1:0] a_el, b_el;
  logic [OW-1:0] prod_ext;
`ifdef MATMUL_SIGNED_EN
  logic signed [2*DW-1:0] prod_s;
  logic signed [OW-1:0]   prod_sx;
`else
  logic [2*DW-1:0] prod_u;
`endif

  always_comb begin
    a_el = a_q[i_q][k_q];
    b_el = b_q[k_q][j_q];
`ifdef MATMUL_SIGNED_EN
    prod_s   = $signed(a_el) * $signed(b_el);
    prod_sx  = prod_s;
    prod_ext = prod_sx;
`else
    prod_u   = a_el * b_el;
    prod_ext = OW'(prod_u);
`endif
    acc_d = acc_q + prod_ext;
  end

  // Operand memories; index compares keep out-of-range writes harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < K; c++) a_q[r][c] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < N; c++) b_q[r][c] <= '0;
    end else if (data_in && !busy_q) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < K; c++)
          if (!mem_sel && row_in == AW'(r) && col_in == AW'(c)) a_q[r][c] <= data;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < N; c++)
          if (mem_sel && row_in == AW'(r) && col_in == AW'(c)) b_q[r][c] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++) c_q[r][c] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= MAC;
            busy_q  <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
          end
        end
        MAC: begin
          if (k_q == KW'(K-1)) begin
            c_q[i_q][j_q] <= acc_d;
            acc_q <= '0;
            k_q   <= '0;
            if (j_q == JW'(N-1)) begin
              j_q <= '0;
              if (i_q == IW'(M-1)) begin
                i_q     <= '0;
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= acc_d;
            k_q   <= k_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        if (row_out == AW'(r) && col_out == AW'(c)) rd_d = c_q[r][c];
  end

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= rd_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine: a reference model pushes expected C reads to a queue.
module tb_matmul_engine;
  localparam int DW = 8, M = 2, K = 3, N = 3, AW = 2;
  localparam int OW = 2*DW + $clog2(K);
  localparam longint MASK = (longint'(1) << OW) - 1;

  logic          clk = 1'b0;
  logic          reset, data_in, mem_sel, start;
  logic [DW-1:0] data;
  logic [AW-1:0] row_in, col_in, row_out, col_out;
  logic          busy, done;
  logic [OW-1:0] out;

  matmul_engine #(.DW(DW), .M(M), .K(K), .N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .mem_sel(mem_sel), .data(data),
    .row_in(row_in), .col_in(col_in), .start(start), .busy(busy), .done(done),
    .row_out(row_out), .col_out(col_out), .out(out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] ma [M][K];
  logic [DW-1:0] mb [K][N];
  longint exp_q [$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sval(input logic [DW-1:0] x);
`ifdef MATMUL_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  function automatic longint model_c(input int r, input int c);
    longint s = 0;
    if (r >= M || c >= N) return 0;
    for (int k = 0; k < K; k++) s += sval(ma[r][k]) * sval(mb[k][c]);
    return s & MASK;
  endfunction

  task automatic wr(input logic sel, input int r, input int c, input logic [DW-1:0] v);
    @(negedge clk);
    data_in = 1'b1; mem_sel = sel; row_in = AW'(r); col_in = AW'(c); data = v;
    @(posedge clk);
    #1 data_in = 1'b0;
    if (sel == 1'b0 && r < M && c < K) ma[r][c] = v;
    if (sel == 1'b1 && r < K && c < N) mb[r][c] = v;
  endtask

  task automatic read_c(input string tag, input int r, input int c);
    logic [OW-1:0] ov;
    @(negedge clk);
    row_out = AW'(r); col_out = AW'(c);
    exp_q.push_back(model_c(r, c));
    @(posedge clk);
    #1 ov = out;
    check(tag, longint'(ov), exp_q.pop_front());
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) read_c(tag, r, c);
  endtask

  task automatic clear_model();
    for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) ma[r][c] = '0;
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) mb[r][c] = '0;
  endtask

  task automatic run_mac(input bit lockout);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (lockout && n == 3) begin
        data_in = 1'b1; mem_sel = 1'b0; row_in = '0; col_in = '0; data = 8'd99; start = 1'b1;
      end else begin
        data_in = 1'b0; start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = n;
      end
    end
    check("busy_cycles", busy_n, M*N*K);
    check("done_at", done_at, M*N*K + 1);
    check("done_count", done_n, 1);
  endtask

  initial begin
    int done_n;
    reset = 1'b1; data_in = 1'b0; mem_sel = 1'b0; start = 1'b0; data = '0;
    row_in = '0; col_in = '0; row_out = '0; col_out = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_out", longint'(out), 0);
    read_c("rst_c12", 1, 2);

    // Full multiply, with out-of-range writes that must be dropped.
    for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) wr(1'b0, r, c, DW'(r*K + c + 1));
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) wr(1'b1, r, c, DW'(r*N + c + 7));
    wr(1'b0, 2, 0, 8'd50);
    wr(1'b1, 0, 3, 8'd50);
    run_mac(1'b0);
    read_all("basic");
    read_c("oor_row", 2, 0);
    read_c("oor_col", 0, 3);

    // Busy lockout: write and second start during MAC are ignored.
    run_mac(1'b1);
    read_all("lockout");

    // Overflow bound.
    for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) wr(1'b0, r, c, 8'hFF);
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) wr(1'b1, r, c, 8'hFF);
    run_mac(1'b0);
    read_all("ovf");

    // Reset abort at cycle 5 of MAC.
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_pre", longint'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_model();
    check("abort_busy", longint'(busy), 0);
    done_n = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", done_n, 0);
    read_c("abort_c00", 0, 0);
    for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) wr(1'b0, r, c, DW'(r*K + c + 1));
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) wr(1'b1, r, c, DW'(r*N + c + 7));
    run_mac(1'b0);
    read_all("rerun");

    // Signed-mode vector (unsigned interpretation in the default build).
    wr(1'b0, 0, 0, 8'hFF); wr(1'b0, 0, 1, 8'hFF); wr(1'b0, 0, 2, 8'hFF);
    wr(1'b0, 1, 0, 8'd2);  wr(1'b0, 1, 1, 8'd0);  wr(1'b0, 1, 2, 8'd0);
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) wr(1'b1, r, c, 8'd2);
    run_mac(1'b0);
    read_all("sgn");

    // Start coincident with reset is ignored.
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", longint'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
